// File: rtl/dual_issue_scheduler.sv
// In-order issue queue feeding ALU lanes A and B; pairs the two oldest ops
// unless a branch or an intra-pair RAW hazard forbids it.
module dis_slot #(
  parameter int OP_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_vld,
  input  logic [OP_W-1:0] i_op,
  output logic            o_vld,
  output logic [OP_W-1:0] o_op
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vld <= 1'b0;
      o_op  <= '0;
    end else if (i_flush) begin
      o_vld <= 1'b0;
      o_op  <= '0;
    end else if (i_load) begin
      o_vld <= i_vld;
      o_op  <= i_vld ? i_op : '0;
    end
  end
endmodule

module dual_issue_scheduler #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  input  logic [23:0]      in_op0,
  input  logic [23:0]      in_op1,
  output logic             in_ready,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             issue_valid_a,
  output logic [23:0]      issue_op_a,
  output logic             issue_valid_b,
  output logic [23:0]      issue_op_b,
  output logic [CNT_W-1:0] dual_cnt
);
  localparam int AW        = $clog2(DEPTH);
  localparam int OP_W      = 24;
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic       is_branch;
    logic       reg_write;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] alu_ctrl;
    logic [2:0] funct3;
  } op_t;

  logic [OP_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_rd, r_wr;
  logic [AW:0]     r_cnt;
  logic [CNT_W-1:0] r_dual;

  op_t         w_e0, w_e1;
  logic        w_haz, w_ca, w_cb, w_adv, w_push0, w_push1;
  logic [AW:0] w_push_n, w_pop_n;

  assign w_e0 = op_t'(r_mem[r_rd]);
  assign w_e1 = op_t'(r_mem[r_rd + AW'(1)]);

  // x0 is never a real destination, so it cannot create a RAW hazard
  assign w_haz = w_e0.reg_write && (w_e0.rd != 5'd0) &&
                 ((w_e1.rs1 == w_e0.rd) || (w_e1.rs2 == w_e0.rd));
  assign w_ca  = (r_cnt != '0);
  assign w_cb  = (r_cnt >= (AW+1)'(2)) && !w_e0.is_branch && !w_e1.is_branch && !w_haz;

  assign in_ready = (r_cnt <= (AW+1)'(DEPTH-2));
  assign w_adv    = !stall_i && !flush_i;
  assign w_push0  = in_ready && in_valid[0] && !flush_i;
  assign w_push1  = w_push0 && in_valid[1];
  assign w_push_n = (AW+1)'(w_push0) + (AW+1)'(w_push1);
  assign w_pop_n  = (AW+1)'(w_adv && w_ca) + (AW+1)'(w_adv && w_cb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_rd  <= r_rd + AW'(w_pop_n);
      r_wr  <= r_wr + AW'(w_push_n);
      r_cnt <= r_cnt + w_push_n - w_pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push0) r_mem[r_wr] <= in_op0;
    if (w_push1) r_mem[r_wr + AW'(1)] <= in_op1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_dual <= '0;
    else if (w_adv && w_cb && (r_dual != '1))
      r_dual <= r_dual + 1'b1;
  end
  assign dual_cnt = r_dual;

  logic [NUM_LANES-1:0]           w_ld_vld, w_slot_vld;
  logic [NUM_LANES-1:0][OP_W-1:0] w_ld_op, w_slot_op;

  assign w_ld_vld = {w_cb, w_ca};
  assign w_ld_op  = {w_e1, w_e0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dis_slot #(.OP_W(OP_W)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .i_flush(flush_i),
      .i_load (w_adv),
      .i_vld  (w_ld_vld[g]),
      .i_op   (w_ld_op[g]),
      .o_vld  (w_slot_vld[g]),
      .o_op   (w_slot_op[g])
    );
  end

  assign issue_valid_a = w_slot_vld[0];
  assign issue_op_a    = w_slot_op[0];
  assign issue_valid_b = w_slot_vld[1];
  assign issue_op_b    = w_slot_op[1];
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: queue-based scoreboard plus
// a pairing vector table and hand-built stall/flush/saturation/reset sequences.
module tb_dual_issue_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [23:0] in_op0, in_op1;
  logic        in_ready, stall_i, flush_i;
  logic        issue_valid_a, issue_valid_b;
  logic [23:0] issue_op_a, issue_op_b;
  logic [3:0]  dual_cnt;

  dual_issue_scheduler #(.DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op0(in_op0), .in_op1(in_op1),
    .in_ready(in_ready), .stall_i(stall_i), .flush_i(flush_i),
    .issue_valid_a(issue_valid_a), .issue_op_a(issue_op_a),
    .issue_valid_b(issue_valid_b), .issue_op_b(issue_op_b), .dual_cnt(dual_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Scoreboard: accepted ops in program order, popped as the lanes issue them
  logic [23:0] mq[$];
  logic        m_va, m_vb;
  logic [23:0] m_oa, m_ob;
  int          m_cnt;

  function automatic logic [23:0] mk(bit br, bit rw, int rd, int rs1, int rs2, int alu);
    return {br, rw, 5'(rd), 5'(rs1), 5'(rs2), 4'(alu), 3'd0};
  endfunction

  function automatic bit can_pair(logic [23:0] a, logic [23:0] b);
    bit raw;
    raw = a[22] && (a[21:17] != 5'd0) && (b[16:12] == a[21:17] || b[11:7] == a[21:17]);
    return !a[23] && !b[23] && !raw;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_va = 0; m_vb = 0; m_oa = '0; m_ob = '0; m_cnt = 0;
  endtask

  task automatic step(logic [1:0] vin, logic [23:0] o0, logic [23:0] o1, bit st, bit fl);
    bit rdy;
    @(negedge clk);
    in_valid = vin; in_op0 = o0; in_op1 = o1; stall_i = st; flush_i = fl;
    rdy = (mq.size() <= 6);
    #1 check("in_ready", in_ready, rdy);
    if (fl) begin
      mq.delete();
      m_va = 0; m_vb = 0; m_oa = '0; m_ob = '0;
    end else begin
      if (!st) begin
        m_va = (mq.size() >= 1);
        m_vb = (mq.size() >= 2) && can_pair(mq[0], mq[1]);
        m_oa = m_va ? mq[0] : '0;
        m_ob = m_vb ? mq[1] : '0;
        if (m_va) void'(mq.pop_front());
        if (m_vb) void'(mq.pop_front());
        if (m_vb && m_cnt < 15) m_cnt++;
      end
      if (rdy && vin[0]) begin
        mq.push_back(o0);
        if (vin[1]) mq.push_back(o1);
      end
    end
    @(posedge clk);
    #1;
    check("valid_a", issue_valid_a, m_va);
    check("op_a", issue_op_a, m_oa);
    check("valid_b", issue_valid_b, m_vb);
    check("op_b", issue_op_b, m_ob);
    check("dual_cnt", dual_cnt, m_cnt);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(2'b00, '0, '0, 0, 0);
  endtask

  typedef struct {
    logic [23:0] op0;
    logic [23:0] op1;
    bit          dual;
  } vec_t;

  vec_t vt[7];

  initial begin
    rst = 1; in_valid = 0; in_op0 = 0; in_op1 = 0; stall_i = 0; flush_i = 0;
    model_reset();
    vt[0] = '{mk(0,1,1,2,3,0), mk(0,1,4,5,6,0), 1};  // independent adds
    vt[1] = '{mk(0,1,1,2,3,0), mk(0,1,7,1,2,8), 0};  // RAW on x1
    vt[2] = '{mk(0,1,0,2,3,0), mk(0,1,3,0,0,6), 1};  // x0 dest exempt
    vt[3] = '{mk(1,0,0,1,2,8), mk(0,1,4,5,6,0), 0};  // older branch
    vt[4] = '{mk(0,1,1,2,3,0), mk(1,0,0,4,5,8), 0};  // younger branch
    vt[5] = '{mk(0,1,5,1,2,0), mk(0,0,0,3,5,0), 0};  // store reads x5
    vt[6] = '{mk(0,0,5,1,2,0), mk(0,1,6,5,5,0), 1};  // no write, no hazard

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    #1;
    check("rst_valid_a", issue_valid_a, 0);
    check("rst_valid_b", issue_valid_b, 0);
    check("rst_op_a", issue_op_a, 0);
    check("rst_op_b", issue_op_b, 0);
    check("rst_dual", dual_cnt, 0);
    check("rst_ready", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      step(2'b11, vt[i].op0, vt[i].op1, 0, 0);
      step(2'b00, '0, '0, 0, 0);
      check("vec_dual", issue_valid_b, vt[i].dual);
      check("vec_op_a", issue_op_a, vt[i].op0);
      idle(2);
    end

    // Stall while filling: slots keep the first pair, 5th pair is refused
    step(2'b11, mk(0,1,10,1,2,0), mk(0,1,11,1,2,0), 0, 0);
    step(2'b00, '0, '0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(2'b11, mk(0,1,12+2*i,1,2,0), mk(0,1,13+2*i,1,2,0), 1, 0);
    check("full_ready", in_ready, 0);
    check("stall_hold_a", issue_op_a, mk(0,1,10,1,2,0));
    check("queue_depth", mq.size(), 8);
    step(2'b00, '0, '0, 0, 0);
    check("drain_dual", issue_valid_b, 1);
    idle(4);

    // Flush beats stall and same-cycle enqueue
    step(2'b11, mk(0,1,3,1,2,0), mk(0,1,4,1,2,0), 0, 0);
    step(2'b00, '0, '0, 0, 0);
    step(2'b11, mk(0,1,5,1,2,0), mk(0,1,6,1,2,0), 0, 0);
    step(2'b11, mk(0,1,7,1,2,0), mk(0,1,8,1,2,0), 1, 1);
    check("flush_valid_a", issue_valid_a, 0);
    idle(2);
    check("flush_dropped", issue_valid_a, 0);

    // Saturate the 4-bit counter with back-to-back independent pairs
    for (int i = 0; i < 20; i++)
      step(2'b11, mk(0,1,10+(i%8),1,2,0), mk(0,1,20+(i%8),3,4,0), 0, 0);
    idle(2);
    check("dual_sat", dual_cnt, 15);

    // Async reset mid-burst, no clock edge needed
    step(2'b11, mk(0,1,9,1,2,0), mk(0,1,10,1,2,0), 0, 0);
    step(2'b11, mk(0,1,11,1,2,0), mk(0,1,12,1,2,0), 0, 0);
    @(negedge clk);
    in_valid = 0;
    #2 rst = 1;
    #1;
    check("arst_valid_a", issue_valid_a, 0);
    check("arst_op_a", issue_op_a, 0);
    check("arst_valid_b", issue_valid_b, 0);
    check("arst_dual", dual_cnt, 0);
    check("arst_ready", in_ready, 1);
    model_reset();
    @(negedge clk); rst = 0;
    step(2'b11, mk(0,1,1,2,3,0), mk(0,1,4,5,6,0), 0, 0);
    idle(2);
    check("post_rst_dual", dual_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
